// File: rtl/encrypt_cbc_ctrl_if.sv
// encrypt_cbc_ctrl_if: plaintext stream, ciphertext stream and encrypt-core
// req/ack bus of the CBC chaining controller.
// master: the controller side; slave: the environment (source, sink, core).
interface encrypt_cbc_ctrl_if #(
  parameter int N_B = 64,
  parameter int N_K = 80
);
  logic           in_valid;
  logic           in_ready;
  logic [N_B-1:0] in_m;
  logic           out_valid;
  logic           out_ready;
  logic [N_B-1:0] out_c;
  logic           core_req;
  logic           core_ack;
  logic [N_K-1:0] core_k;
  logic [N_B-1:0] core_m;
  logic [N_B-1:0] core_c;

  modport master (
    input  in_valid, in_m, out_ready, core_ack, core_c,
    output in_ready, out_valid, out_c, core_req, core_k, core_m
  );

  modport slave (
    output in_valid, in_m, out_ready, core_ack, core_c,
    input  in_ready, out_valid, out_c, core_req, core_k, core_m
  );
endinterface

// File: rtl/encrypt_cbc_ctrl.sv
// encrypt_cbc_ctrl: CBC chaining controller in front of a 4-phase req/ack
// encrypt core. Each accepted block is XORed with the previous ciphertext
// (or the IV), sent through one full req/ack cycle, and the ciphertext is
// returned on a valid/ready stream.
// Optional feature macro: ENCRYPT_CBC_ECB_EN adds input ecb; a block accepted
// with ecb=1 bypasses the chaining XOR and leaves the chain register untouched.
module encrypt_cbc_ctrl #(
  parameter int N_B = 64,
  parameter int N_K = 80
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ENCRYPT_CBC_ECB_EN
  input  logic           ecb,
`endif
  input  logic [N_K-1:0] k,
  input  logic           iv_ld,
  input  logic [N_B-1:0] iv,
  encrypt_cbc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N_B-1:0] r_chain;
  logic [N_B-1:0] r_core_m;
  logic [N_B-1:0] r_out_c;
  logic [N_B-1:0] w_core_m_nxt;
  logic           r_core_req;
  logic           r_out_valid;
  logic           r_ecb;
  logic           w_ecb;
  logic           w_in_ready;
  logic           w_accept;

`ifdef ENCRYPT_CBC_ECB_EN
  assign w_ecb = ecb;
`else
  assign w_ecb = 1'b0;
`endif

  // Next state, acceptance gating and the block presented to the core.
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_core_m_nxt = w_ecb ? bus.in_m : (bus.in_m ^ r_chain);
    case (r_state)
      ST_IDLE: begin
        // IV load wins over acceptance; a still-high ack from a stale
        // request blocks acceptance so req never rises while ack=1.
        w_in_ready = !rst && !iv_ld && !bus.core_ack;
        w_accept   = w_in_ready && bus.in_valid;
        if (w_accept) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.core_ack) begin
          w_state_nxt = ST_REL;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REL: begin
        if (!bus.core_ack) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_REL;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered core_req / out_valid decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_core_req  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_core_req  <= (w_state_nxt == ST_REQ);
      r_out_valid <= (w_state_nxt == ST_OUT);
    end
  end

  // Datapath: chain register, core input block and ciphertext holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain  <= {N_B{1'b0}};
      r_core_m <= {N_B{1'b0}};
      r_out_c  <= {N_B{1'b0}};
      r_ecb    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iv_ld) begin
            r_chain <= iv;
          end else if (w_accept) begin
            r_core_m <= w_core_m_nxt;
            r_ecb    <= w_ecb;
          end
        end
        ST_REQ: begin
          if (bus.core_ack) begin
            r_out_c <= bus.core_c;
            if (!r_ecb) begin
              r_chain <= bus.core_c;
            end
          end
        end
        default: begin
          r_chain <= r_chain;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_c     = r_out_c;
  assign bus.core_req  = r_core_req;
  assign bus.core_m    = r_core_m;
  assign bus.core_k    = k;

endmodule

// File: tb/tb_encrypt_cbc_ctrl.sv
// tb_encrypt_cbc_ctrl: directed + randomized bench for encrypt_cbc_ctrl with a
// stub core (c = m ^ k[63:0], ack raised D cycles after req, dropped D cycles
// after req falls). Builds with or without ENCRYPT_CBC_ECB_EN.
module tb_encrypt_cbc_ctrl;
  localparam int N_B = 64;
  localparam int N_K = 80;

  logic           clk;
  logic           rst;
  logic           ecb;
  logic [N_K-1:0] key;
  logic           iv_ld;
  logic [N_B-1:0] iv;

  int vectors;
  int miscompares;

  // reference model state: chaining value as the specification defines it
  logic [N_B-1:0] chain_q;

  // stub core
  int unsigned stub_d;
  int unsigned stub_cnt;
  logic        stub_ack_r;
  logic        ack_s;

  // monitors
  int   xfer;
  int   viol;
  logic prev_req;
  logic prev_ack;

  encrypt_cbc_ctrl_if #(.N_B(N_B), .N_K(N_K)) bus ();

  encrypt_cbc_ctrl #(.N_B(N_B), .N_K(N_K)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ENCRYPT_CBC_ECB_EN
    .ecb   (ecb),
`endif
    .k     (key),
    .iv_ld (iv_ld),
    .iv    (iv),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub core acknowledge with D-cycle delay on both edges
  always_comb begin
    if (!stub_ack_r) ack_s = bus.core_req && (stub_cnt >= stub_d);
    else             ack_s = !(!bus.core_req && (stub_cnt >= stub_d));
  end
  assign bus.core_ack = ack_s;
  assign bus.core_c   = bus.core_m ^ bus.core_k[N_B-1:0];

  always @(posedge clk) begin
    if (ack_s != stub_ack_r)                       stub_cnt <= 0;
    else if (stub_ack_r ? !bus.core_req : bus.core_req) stub_cnt <= stub_cnt + 1;
    else                                           stub_cnt <= 0;
    stub_ack_r <= ack_s;
  end

  // count output transfers
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) xfer <= xfer + 1;
  end

  // handshake protocol watch: req may only rise with ack low, only fall after ack
  always @(negedge clk) begin
    if (bus.core_req && !prev_req && prev_ack) viol <= viol + 1;
    if (!bus.core_req && prev_req && !prev_ack && !rst) viol <= viol + 1;
    prev_req <= bus.core_req;
    prev_ack <= bus.core_ack;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // load an IV while the controller is idle (called at a negedge)
  task automatic load_iv(input logic [N_B-1:0] v);
    iv_ld = 1'b1;
    iv    = v;
    @(posedge clk); #1;
    iv_ld   = 1'b0;
    chain_q = v;
    @(negedge clk);
  endtask

  // send one block, check core_m, latency, out_c, backpressure and transfer count
  task automatic send_block(input logic [N_B-1:0] m, input logic e, input int bp, output int waits);
    logic [N_B-1:0] exp_cm;
    logic [N_B-1:0] exp_c;
    int lat;
    int x0;
    exp_cm = e ? m : (m ^ chain_q);
    exp_c  = exp_cm ^ key[N_B-1:0];
    bus.in_m      = m;
    ecb           = e;
    bus.in_valid  = 1'b1;
    bus.out_ready = (bp == 0);
    waits = 0;
    #1;
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk); #1;
      waits++;
    end
    chk("accept_bound", 32'(waits < 100), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    x0 = xfer;
    chk("req_rise", bus.core_req, 1'b1);
    chk("core_m", bus.core_m, exp_cm);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 2 + 2 * stub_d);
    chk("out_c", bus.out_c, exp_c);
    if (!e) chain_q = exp_c;
    if (bp > 0) begin
      iv_ld = 1'b1;
      iv    = {$urandom, $urandom};
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_out_c", bus.out_c, exp_c);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    iv_ld = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", bus.out_valid, 1'b0);
    chk("xfer_once", xfer - x0, 1);
    chk("core_m_hold", bus.core_m, exp_cm);
    @(negedge clk);
  endtask

  initial begin
    int w;
    int n;
    logic [N_B-1:0] m;
    vectors = 0; miscompares = 0;
    xfer = 0; viol = 0; prev_req = 1'b0; prev_ack = 1'b0;
    stub_d = 0; stub_cnt = 0; stub_ack_r = 1'b0;
    rst = 1'b1; ecb = 1'b0; iv_ld = 1'b0; iv = '0;
    key = {16'h5A5A, 64'h0F0F0F0F0F0F0F0F};
    bus.in_valid = 1'b0; bus.in_m = '0; bus.out_ready = 1'b1;
    chain_q = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_core_req", bus.core_req, 1'b0);
    chk("rst_out_c", bus.out_c, 64'h0);
    chk("rst_core_m", bus.core_m, 64'h0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // chain two blocks, D=0
    load_iv(64'h0123456789ABCDEF);
    send_block(64'h0, 1'b0, 0, w);
    chk("dir0_core_m", bus.core_m, 64'h0123456789ABCDEF);
    chk("dir0_out_c", bus.out_c, 64'h0E2C4A6886A4C2E0);
    send_block(64'h0, 1'b0, 0, w);
    chk("dir1_core_m", bus.core_m, 64'h0E2C4A6886A4C2E0);
    chk("dir1_out_c", bus.out_c, 64'h0123456789ABCDEF);

    // output backpressure for 10 cycles (with an ignored iv_ld outside IDLE)
    send_block({$urandom, $urandom}, 1'b0, 10, w);
    send_block({$urandom, $urandom}, 1'b0, 0, w);

    // slow core D=5, same vectors
    stub_d = 5;
    load_iv(64'h0123456789ABCDEF);
    send_block(64'h0, 1'b0, 0, w);
    chk("slow0_out_c", bus.out_c, 64'h0E2C4A6886A4C2E0);
    send_block(64'h0, 1'b0, 0, w);
    chk("slow1_out_c", bus.out_c, 64'h0123456789ABCDEF);

    // reset in REQ while ack=1, D=3
    stub_d = 3;
    bus.in_m = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.in_ready && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.core_ack && n < 20) begin @(posedge clk); #1; n++; end
    chk("ack_in_req", bus.core_ack & bus.core_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chain_q = '0;
    chk("mid_rst_req", bus.core_req, 1'b0);
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_c", bus.out_c, 64'h0);
    n = 0;
    while (bus.core_ack && n < 20) begin
      chk("stale_ack_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    chk("stale_ack_cycles", n, 3);
    chk("ack_released_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    m = {$urandom, $urandom};
    send_block(m, 1'b0, 0, w);
    chk("post_rst_core_m", bus.core_m, m);

    // IV priority over a simultaneous block
    stub_d = 0;
    m = {$urandom, $urandom};
    iv_ld = 1'b1;
    iv    = {$urandom, $urandom};
    bus.in_m = m;
    bus.in_valid = 1'b1;
    #1;
    chk("ivp_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    iv_ld = 1'b0;
    chain_q = iv;
    chk("ivp_no_accept", bus.core_req, 1'b0);
    send_block(m, 1'b0, 0, w);
    chk("ivp_next_cycle", w, 0);

    // randomized blocks against the reference model
    for (int i = 0; i < 10; i++) begin
      stub_d = $urandom_range(0, 3);
      key = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) load_iv({$urandom, $urandom});
`ifdef ENCRYPT_CBC_ECB_EN
      send_block({$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 3), w);
`else
      send_block({$urandom, $urandom}, 1'b0, $urandom_range(0, 3), w);
`endif
    end

`ifdef ENCRYPT_CBC_ECB_EN
    // ECB block must not update the chain
    stub_d = 0;
    key = {16'h5A5A, 64'h0F0F0F0F0F0F0F0F};
    load_iv(64'h0123456789ABCDEF);
    m = {$urandom, $urandom};
    send_block(m, 1'b1, 0, w);
    chk("ecb_c0", bus.out_c, m ^ 64'h0F0F0F0F0F0F0F0F);
    send_block(64'h0, 1'b0, 0, w);
    chk("ecb_c1", bus.out_c, 64'h0E2C4A6886A4C2E0);
`endif

    repeat (2) @(negedge clk);
    chk("req_ack_protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/encrypt_cbc_ctrl.md
Name: encrypt_cbc_ctrl

Overview:
- Chaining controller placed directly in front of the encrypt core, which uses a 4-phase req/ack handshake.
- Accepts a stream of plaintext blocks over valid/ready and forms CBC input (m XOR previous ciphertext, IV for the first block).
- Drives the core through one full req/ack cycle per block and returns each ciphertext over a valid/ready output stream.
- Chaining state is held across blocks until a new IV is loaded.

Parameters:
- N_B, 64: block width in bits; must equal the core's `N_B`.
- N_K, 80: key width in bits; must equal the core's `N_K`.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- k  in  N_K  cipher key; passed through unregistered to core_k.
- iv_ld  in  1  load IV; honoured only in IDLE.
- iv  in  N_B  initialisation vector.
- in_valid  in  1  plaintext block valid.
- in_ready  out  1  controller can accept a block.
- in_m  in  N_B  plaintext block.
- out_valid  out  1  ciphertext block valid.
- out_ready  in  1  downstream accepts the ciphertext.
- out_c  out  N_B  ciphertext block.
- core_req  out  1  request to the encrypt core.
- core_ack  in  1  acknowledge from the encrypt core.
- core_k  out  N_K  key to the core; equals k.
- core_m  out  N_B  registered core input block.
- core_c  in  N_B  core output block.

Behaviour:
- Reset values: in_ready=0, out_valid=0, core_req=0, out_c=0, core_m=0, chain register=0, state=IDLE.
- States: IDLE, REQ, REL, OUT.
- IDLE:
  - in_ready = !iv_ld & !core_ack.
  - iv_ld=1 → chain<=iv; no block is accepted that cycle (IV load has priority).
  - in_valid & in_ready → core_m<=in_m^chain, then REQ.
- REQ: core_req=1. On core_ack=1, out_c<=core_c and chain<=core_c, then REL.
- REL: core_req=0. On core_ack=0, go to OUT.
- OUT:
  - out_valid=1.
  - out_valid & out_ready → IDLE.
  - out_c is held stable while out_valid=1 and out_ready=0.
- core_m is stable from the REQ entry edge until return to IDLE.
- core_req never rises while core_ack=1. This is guaranteed by the IDLE gating above.
- Latency with zero-wait core and downstream (acceptance edge to out_valid): 1 REQ cycle + 1 REL cycle + core delays.
- Steady-state throughput: one block per 4 + core-delay cycles.
- Reset mid-operation:
  - State returns to IDLE and core_req drops on the same edge.
  - Any in-flight ciphertext is discarded and the chain register clears to 0.
  - If the core still holds ack=1, in_ready stays 0 until ack falls, so a new request never overlaps a stale one.
- iv_ld outside IDLE is ignored; the chain register is not modified.
- Widths: all XORs are exactly N_B bits; no truncation or extension.

Optional Feature:
- Macro: ENCRYPT_CBC_ECB_EN.
- Defined:
  - Adds input port `ecb` (1 bit), sampled at block acceptance.
  - ecb=1 → core_m<=in_m and the chain register is left unchanged at REQ completion (ECB block).
  - ecb=0 → normal CBC behaviour.
- Undefined: no `ecb` port; every block is CBC chained.

Test Plan (bench uses a stub core: c = m ^ k[N_B-1:0], ack raised D cycles after req and dropped D cycles after req falls; D selectable):
- Chain two blocks, D=0. Set k[63:0]=64'h0F0F0F0F0F0F0F0F, iv_ld with iv=64'h0123456789ABCDEF, send m0=0 then m1=0.
  - Expect core_m=0123456789ABCDEF, out_c=0E2C4A6886A4C2E0.
  - Then core_m=0E2C4A6886A4C2E0, out_c=0123456789ABCDEF.
- Output backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Expect out_c stable, in_ready=0 throughout, and exactly one output transfer once out_ready=1.
- Slow core, D=5: same vectors as the first scenario.
  - Expect identical outputs.
  - core_req stays high until ack and never re-rises while ack=1.
  - Cycle from acceptance to out_valid = 2+2D.
- Reset in REQ after ack=1 (D=3): assert rst for 1 cycle.
  - Expect core_req=0 and out_valid=0 next edge.
  - in_ready=0 until the stub drops ack.
  - The next block is chained against chain=0 unless an IV is reloaded.
- IV priority: assert iv_ld and in_valid together in IDLE.
  - Expect the IV loaded, no block accepted that cycle, and the block accepted the following cycle using the new IV.
- With ENCRYPT_CBC_ECB_EN: send m0 with ecb=1, then m1=0 with ecb=0, iv=0123456789ABCDEF.
  - Expect c0 = m0^k.
  - Expect c1 = iv^k = 0E2C4A6886A4C2E0, i.e. the chain was not updated by the ECB block.
